// File: rtl/svc_rv_io_pkg.sv
// Shared register map, STATUS bit positions and UART state encodings for svc_rv_io_uart.
package svc_rv_io_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   localparam int unsigned ST_TX_FULL      = 0;
   localparam int unsigned ST_TX_EMPTY     = 1;
   localparam int unsigned ST_RX_VALID     = 2;
   localparam int unsigned ST_RX_OVERRUN   = 3;
   localparam int unsigned ST_RX_FRAME_ERR = 4;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   // A divisor below 2 would leave no room for the mid-bit sample point.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d < 16'd2) ? 16'd2 : d;
   endfunction

endpackage

// File: rtl/svc_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; a push while full is dropped.
module svc_sync_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/svc_rv_io_uart.sv
// MMIO UART: DATA/STATUS/DIV registers, FIFO-fed transmitter.
// Receiver is compiled in only when SVC_RV_IO_UART_RX_EN is defined.
module svc_rv_io_uart
   import svc_rv_io_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT  = 868,
   parameter int unsigned TX_FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        io_ren,
   input  logic [31:0] io_raddr,
   output logic [31:0] io_rdata,
   input  logic        io_wen,
   input  logic [31:0] io_waddr,
   input  logic [31:0] io_wdata,
   input  logic [3:0]  io_wstrb,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);

   logic [31:0] io_rdata_q, io_rdata_d;
   logic [15:0] div_q, div_d;
   logic        wr_data, wr_div;
   logic        fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata;
   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        tx_q, tx_d;
   logic        tx_bit_end, tx_empty;
   logic        rx_valid, rx_overrun, rx_frame_err;
   logic [7:0]  rx_byte;
   logic [4:0]  status;
   logic        unused_bits;

   assign unused_bits = ^{io_raddr[31:4], io_raddr[1:0], io_waddr[31:4], io_waddr[1:0],
                          io_wdata[31:16], io_wstrb[3:2]};

   assign wr_data = io_wen && (io_waddr[3:2] == REG_DATA) && io_wstrb[0];
   assign wr_div  = io_wen && (io_waddr[3:2] == REG_DIV);

   svc_sync_fifo #(
      .DW    (8),
      .DEPTH (TX_FIFO_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (wr_data),
      .wdata_i (io_wdata[7:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      div_d = div_q;
      if (wr_div && io_wstrb[0]) div_d[7:0]  = io_wdata[7:0];
      if (wr_div && io_wstrb[1]) div_d[15:8] = io_wdata[15:8];
   end

   // ---------------- transmitter ----------------
   assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
   assign tx_empty   = fifo_empty && (tx_state_q == TX_IDLE);
   assign uart_tx    = tx_q;

   // tx_d tracks the level of the state being entered so the line is registered.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_div_d   = tx_div_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      tx_d       = tx_q;
      fifo_pop   = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               tx_shift_d = fifo_rdata;
               tx_div_d   = eff_div(div_q);
               tx_cnt_d   = '0;
               tx_state_d = TX_START;
               tx_d       = 1'b0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
               tx_d       = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  tx_d       = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_d       = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               tx_cnt_d = '0;
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  tx_shift_d = fifo_rdata;
                  tx_div_d   = eff_div(div_q);
                  tx_state_d = TX_START;
                  tx_d       = 1'b0;
               end else begin
                  tx_state_d = TX_IDLE;
                  tx_d       = 1'b1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= 16'd2;
         tx_shift_q <= '0;
         tx_bit_q   <= '0;
         tx_q       <= 1'b1;
         div_q      <= DIV_RST;
         io_rdata_q <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q   <= tx_bit_d;
         tx_q       <= tx_d;
         div_q      <= div_d;
         io_rdata_q <= io_rdata_d;
      end
   end

   // ---------------- receiver ----------------
`ifdef SVC_RV_IO_UART_RX_EN
   logic        rx_s1_q, rx_s2_q, rx_s3_q;
   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
   logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
   logic        rx_done, rx_stop_ok, rd_data, wr_status, rx_bit_end;

   assign rd_data    = io_ren && (io_raddr[3:2] == REG_DATA);
   assign wr_status  = io_wen && (io_waddr[3:2] == REG_STATUS) && io_wstrb[0];
   assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_div_d   = rx_div_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      rx_stop_ok = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_s3_q && !rx_s2_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
               rx_div_d   = eff_div(div_q);
            end
         end
         RX_START: begin
            if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_bit_end) begin
               rx_cnt_d   = '0;
               rx_done    = 1'b1;
               rx_stop_ok = rx_s2_q;
               rx_state_d = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // A byte landing in the same cycle as a DATA read replaces the one being consumed.
   always_comb begin
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = rx_ovr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_byte_d  = rx_byte_q;
      if (rd_data) rx_valid_d = 1'b0;
      if (wr_status && io_wdata[3]) rx_ovr_d  = 1'b0;
      if (wr_status && io_wdata[4]) rx_ferr_d = 1'b0;
      if (rx_done) begin
         if (!rx_stop_ok) begin
            rx_ferr_d = 1'b1;
         end else if (rx_valid_q && !rd_data) begin
            rx_ovr_d = 1'b1;
         end else begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_div_q   <= 16'd2;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_s1_q    <= uart_rx;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

   assign rx_valid     = rx_valid_q;
   assign rx_overrun   = rx_ovr_q;
   assign rx_frame_err = rx_ferr_q;
   assign rx_byte      = rx_byte_q;
`else
   logic unused_rx;
   assign unused_rx    = uart_rx;
   assign rx_valid     = 1'b0;
   assign rx_overrun   = 1'b0;
   assign rx_frame_err = 1'b0;
   assign rx_byte      = '0;
`endif

   // ---------------- read path ----------------
   always_comb begin
      status                  = '0;
      status[ST_TX_FULL]      = fifo_full;
      status[ST_TX_EMPTY]     = tx_empty;
      status[ST_RX_VALID]     = rx_valid;
      status[ST_RX_OVERRUN]   = rx_overrun;
      status[ST_RX_FRAME_ERR] = rx_frame_err;
   end

   always_comb begin
      io_rdata_d = io_rdata_q;
      if (io_ren) begin
         case (io_raddr[3:2])
            REG_DATA:   io_rdata_d = {24'b0, rx_byte};
            REG_STATUS: io_rdata_d = {27'b0, status};
            REG_DIV:    io_rdata_d = {16'b0, div_q};
            REG_RSVD:   io_rdata_d = '0;
            default:    io_rdata_d = '0;
         endcase
      end
   end

   assign io_rdata = io_rdata_q;

endmodule

// File: tb/tb_svc_rv_io_uart.sv
// Directed self-checking bench for svc_rv_io_uart (RX checks run when SVC_RV_IO_UART_RX_EN is defined).
module tb_svc_rv_io_uart;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        io_ren;
   logic [31:0] io_raddr;
   logic [31:0] io_rdata;
   logic        io_wen;
   logic [31:0] io_waddr;
   logic [31:0] io_wdata;
   logic [3:0]  io_wstrb;
   logic        uart_tx;
   logic        uart_rx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   svc_rv_io_uart #(
      .CLKS_PER_BIT  (868),
      .TX_FIFO_DEPTH (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io_ren   (io_ren),
      .io_raddr (io_raddr),
      .io_rdata (io_rdata),
      .io_wen   (io_wen),
      .io_waddr (io_waddr),
      .io_wdata (io_wdata),
      .io_wstrb (io_wstrb),
      .uart_tx  (uart_tx),
      .uart_rx  (uart_rx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      @(negedge clk);
      io_wen = 1'b1; io_waddr = addr; io_wdata = data; io_wstrb = strb;
      @(negedge clk);
      io_wen = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      @(negedge clk);
      io_ren = 1'b1; io_raddr = addr;
      @(negedge clk);
      io_ren = 1'b0;
      chk(tag, io_rdata, exp);
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (uart_tx !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(uart_tx === 1'b0), 32'd1);
   endtask

   // Called on the negedge of the first start-bit cycle; leaves on the first cycle after stop.
   task automatic check_frame(input string tag, input logic [7:0] b, input int unsigned div);
      logic [9:0] f;
      int bad = 0;
      f = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < int'(div); c++) begin
            if (uart_tx !== f[k]) bad++;
            @(negedge clk);
         end
      end
      chk(tag, 32'(bad), 32'd0);
   endtask

`ifdef SVC_RV_IO_UART_RX_EN
   task automatic send_rx(input logic [7:0] b, input int unsigned div, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         uart_rx = f[k];
         repeat (div) @(negedge clk);
      end
      uart_rx = 1'b1;
   endtask
`endif

   initial begin
      int lows;
      rst_n = 1'b0; io_ren = 1'b0; io_raddr = '0; io_wen = 1'b0;
      io_waddr = '0; io_wdata = '0; io_wstrb = '0; uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("rst_rdata", io_rdata, 32'h0);
      rst_n = 1'b1;

      // reset state and register decode
      rd_chk("rst_status", 32'h4, 32'h2);
      @(negedge clk);
      chk("rdata_hold", io_rdata, 32'h2);
      rd_chk("rst_div", 32'h8, 32'd868);
      rd_chk("rsvd_read", 32'hC, 32'h0);
      rd_chk("status_alias_hi_addr", 32'h1004, 32'h2);
      rd_chk("data_read_default", 32'h0, 32'h0);

      // simultaneous read and write of DIV: read sees the old value
      @(negedge clk);
      io_ren = 1'b1; io_raddr = 32'h8;
      io_wen = 1'b1; io_waddr = 32'h8; io_wdata = 32'h4; io_wstrb = 4'h3;
      @(negedge clk);
      io_ren = 1'b0; io_wen = 1'b0;
      chk("rw_same_cycle_read", io_rdata, 32'd868);
      rd_chk("rw_same_cycle_write", 32'h8, 32'h4);

      // DIV byte lanes
      wr(32'h8, 32'h0000ABCD, 4'h2);
      rd_chk("div_upper_lane", 32'h8, 32'h0000AB04);
      wr(32'h8, 32'h4, 4'h3);
      wr(32'h0, 32'h77, 4'hE);
      rd_chk("data_no_strb0", 32'h4, 32'h2);

      // DIV=4, byte 0x55
      wr(32'h0, 32'h55, 4'h1);
      chk("tx_before_pop", 32'(uart_tx), 32'd1);
      @(negedge clk);
      check_frame("frame_55_div4", 8'h55, 4);
      chk("tx_idle_after_55", 32'(uart_tx), 32'd1);
      rd_chk("tx_empty_after_55", 32'h4, 32'h2);

      // DIV rewrite mid-frame applies at the next frame start
      @(negedge clk);
      io_wen = 1'b1; io_waddr = 32'h0; io_wdata = 32'hC3; io_wstrb = 4'h1;
      @(negedge clk);
      chk("tx_before_pop_c3", 32'(uart_tx), 32'd1);
      io_wdata = 32'h3C;
      @(negedge clk);
      io_waddr = 32'h8; io_wdata = 32'h2; io_wstrb = 4'h3;
      fork
         check_frame("frame_c3_old_div", 8'hC3, 4);
         begin @(negedge clk); io_wen = 1'b0; end
      join
      check_frame("frame_3c_new_div", 8'h3C, 2);
      chk("tx_idle_after_3c", 32'(uart_tx), 32'd1);

      // DIV=1 clamps to 2
      wr(32'h8, 32'h1, 4'h3);
      rd_chk("div_raw_1", 32'h8, 32'h1);
      wr(32'h0, 32'h0F, 4'h1);
      chk("tx_before_pop_0f", 32'(uart_tx), 32'd1);
      @(negedge clk);
      check_frame("frame_0f_div_clamp", 8'h0F, 2);

      // DIV=2, 18 back-to-back writes: 17 accepted, 18th dropped
      wr(32'h8, 32'h2, 4'h3);
      fork
         begin
            for (int k = 0; k < 18; k++) begin
               @(negedge clk);
               io_wen = 1'b1; io_waddr = 32'h0; io_wdata = 32'(8'h40 + k); io_wstrb = 4'h1;
            end
            @(negedge clk);
            io_wen = 1'b0;
            rd_chk("tx_full_after_17", 32'h4, 32'h1);
         end
         begin
            wait_start("burst_start_seen");
            for (int k = 0; k < 17; k++)
               check_frame($sformatf("burst_frame_%0d", k), 8'(8'h40 + k), 2);
            chk("burst_no_18th_frame", 32'(uart_tx), 32'd1);
         end
      join
      rd_chk("burst_drained", 32'h4, 32'h2);

      // reset mid-DATA bit
      wr(32'h8, 32'h4, 4'h3);
      wr(32'h0, 32'h00, 4'h1);
      wr(32'h0, 32'h00, 4'h1);
      wr(32'h0, 32'h00, 4'h1);
      rd_chk("pre_reset_status", 32'h4, 32'h0);
      wait_start("reset_frame_start");
      repeat (8) @(negedge clk);
      chk("tx_low_mid_data", 32'(uart_tx), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("tx_high_after_reset", 32'(uart_tx), 32'd1);
      chk("rdata_cleared_by_reset", io_rdata, 32'h0);
      rst_n = 1'b1;
      rd_chk("fifo_empty_after_reset", 32'h4, 32'h2);
      rd_chk("div_after_reset", 32'h8, 32'd868);
      lows = 0;
      repeat (20) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      chk("no_tx_after_reset", 32'(lows), 32'd0);

`ifdef SVC_RV_IO_UART_RX_EN
      wr(32'h8, 32'h8, 4'h3);
      send_rx(8'hA3, 8, 1'b1);
      repeat (4) @(negedge clk);
      rd_chk("rx_valid_set", 32'h4, 32'h6);
      rd_chk("rx_data_a3", 32'h0, 32'hA3);
      rd_chk("rx_valid_cleared", 32'h4, 32'h2);
      rd_chk("rx_data_reread", 32'h0, 32'hA3);
      rd_chk("rx_reread_no_effect", 32'h4, 32'h2);
      send_rx(8'h11, 8, 1'b1);
      repeat (4) @(negedge clk);
      send_rx(8'h22, 8, 1'b1);
      repeat (4) @(negedge clk);
      rd_chk("rx_overrun_set", 32'h4, 32'hE);
      wr(32'h4, 32'h8, 4'h1);
      rd_chk("rx_overrun_cleared", 32'h4, 32'h6);
      rd_chk("rx_data_first_kept", 32'h0, 32'h11);
      send_rx(8'h5A, 8, 1'b0);
      repeat (4) @(negedge clk);
      rd_chk("rx_frame_err_set", 32'h4, 32'h12);
      wr(32'h4, 32'h10, 4'h1);
      rd_chk("rx_frame_err_cleared", 32'h4, 32'h2);
      rd_chk("rx_bad_byte_discarded", 32'h0, 32'h11);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
